// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer (master) and the reset domains / software (slave).
interface rst_seq_ctrl_if #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned IDX_W       = 2
);
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] dom_ack;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   seq_done;
    logic                   seq_err;
    logic [IDX_W-1:0]       err_dom;

    modport master (
        input  sw_rst_req,
        input  dom_ack,
        output dom_rst_n,
        output seq_done,
        output seq_err,
        output err_dom
    );

    modport slave (
        output sw_rst_req,
        output dom_ack,
        input  dom_rst_n,
        input  seq_done,
        input  seq_err,
        input  err_dom
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset-release sequencer: holds all domain resets, then releases domains one at a time in index
// order, waiting for each acknowledge; reports completion or the index of a failing domain.
module rst_seq_ctrl #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDX_W       = 2
) (
    input logic          clk,
    input logic          rst,
    rst_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        StHold,
        StRelease,
        StWaitAck,
        StGap,
        StDone,
        StError
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_DOMAINS - 1);

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc;
    logic [NUM_DOMAINS-1:0] rst_n_q;
    logic                   done_q;
    logic                   err_q;
    logic [IDX_W-1:0]       err_dom_q;
    logic [IDX_W-1:0]       low_drop;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Lowest-index domain whose ack is currently low; only consulted once all are released.
    always_comb begin
        low_drop = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (!bus.dom_ack[i]) begin
                low_drop = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.sw_rst_req) begin
            state_q   <= StHold;
            idx_q     <= '0;
            cnt_q     <= '0;
            rst_n_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_dom_q <= '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (32'(cnt_q) >= HOLD_CYCLES) begin
                        state_q <= StRelease;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StRelease: begin
                    rst_n_q[idx_q] <= 1'b1;
                    cnt_q          <= '0;
                    state_q        <= StWaitAck;
                end
                StWaitAck: begin
                    if (bus.dom_ack[idx_q]) begin
                        cnt_q <= '0;
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= (GAP_CYCLES == 0) ? StRelease : StGap;
                        end
                    end else if (32'(cnt_q) + 1 >= ACK_TIMEOUT) begin
                        state_q        <= StError;
                        err_q          <= 1'b1;
                        err_dom_q      <= idx_q;
                        rst_n_q[idx_q] <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StGap: begin
                    if (32'(cnt_q) + 1 >= GAP_CYCLES) begin
                        state_q <= StRelease;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDone: begin
                    // Ack loss after completion: flag it but leave every domain released.
                    if (!(&bus.dom_ack)) begin
                        state_q   <= StError;
                        done_q    <= 1'b0;
                        err_q     <= 1'b1;
                        err_dom_q <= low_drop;
                    end
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

    assign bus.dom_rst_n = rst_n_q;
    assign bus.seq_done  = done_q;
    assign bus.seq_err   = err_q;
    assign bus.err_dom   = err_dom_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl; each domain ack is modelled as its reset request delayed by
// two flops, with per-bit overrides to force acks low or high.
module tb_rst_seq_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   cyc;

    logic [3:0] sync1 = '0;
    logic [3:0] sync2 = '0;
    logic [3:0] tie0  = '0;
    logic [3:0] tie1  = '0;

    rst_seq_ctrl_if #(.NUM_DOMAINS(4), .IDX_W(2)) bus ();

    rst_seq_ctrl #(
        .NUM_DOMAINS(4),
        .HOLD_CYCLES(8),
        .GAP_CYCLES (4),
        .ACK_TIMEOUT(16),
        .CNT_W      (8),
        .IDX_W      (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        sync1 <= bus.dom_rst_n;
        sync2 <= sync1;
    end

    assign bus.dom_ack = (sync2 | tie1) & ~tie0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int t);
        while (cyc < t) tick();
    endtask

    // Leaves time just after edge L (first edge sampling rst=0), with cyc=0.
    task automatic do_reset(input bit chk);
        rst = 1'b1;
        repeat (3) tick();
        if (chk) begin
            check_val("rst_dom_rst_n", 32'(bus.dom_rst_n), 32'h0);
            check_val("rst_seq_done", 32'(bus.seq_done), 32'h0);
            check_val("rst_seq_err", 32'(bus.seq_err), 32'h0);
            check_val("rst_err_dom", 32'(bus.err_dom), 32'h0);
        end
        rst = 1'b0;
        tick();
        cyc = 0;
    endtask

    task automatic run_nominal(input string pfx);
        adv_to(8);
        check_val({pfx, "_l8"}, 32'(bus.dom_rst_n), 32'h0);
        adv_to(9);
        check_val({pfx, "_l9"}, 32'(bus.dom_rst_n), 32'h1);
        adv_to(16);
        check_val({pfx, "_l16"}, 32'(bus.dom_rst_n), 32'h1);
        adv_to(17);
        check_val({pfx, "_l17"}, 32'(bus.dom_rst_n), 32'h3);
        adv_to(24);
        check_val({pfx, "_l24"}, 32'(bus.dom_rst_n), 32'h3);
        adv_to(25);
        check_val({pfx, "_l25"}, 32'(bus.dom_rst_n), 32'h7);
        adv_to(33);
        check_val({pfx, "_l33"}, 32'(bus.dom_rst_n), 32'hf);
        adv_to(35);
        check_val({pfx, "_done_l35"}, 32'(bus.seq_done), 32'h0);
        adv_to(36);
        check_val({pfx, "_done_l36"}, 32'(bus.seq_done), 32'h1);
        check_val({pfx, "_err_l36"}, 32'(bus.seq_err), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        rst = 1'b1;
        bus.sw_rst_req = 1'b0;

        // Nominal release sequence.
        do_reset(1'b1);
        run_nominal("s1");

        // Domain 2 never acknowledges: timeout names it and pulls its reset back low.
        tie0 = 4'b0100;
        do_reset(1'b0);
        adv_to(25);
        check_val("s2_l25", 32'(bus.dom_rst_n), 32'h7);
        adv_to(40);
        check_val("s2_err_l40", 32'(bus.seq_err), 32'h0);
        adv_to(41);
        check_val("s2_err_l41", 32'(bus.seq_err), 32'h1);
        check_val("s2_err_dom", 32'(bus.err_dom), 32'h2);
        check_val("s2_rst_n_l41", 32'(bus.dom_rst_n), 32'h3);
        adv_to(50);
        check_val("s2_rst_n_l50", 32'(bus.dom_rst_n), 32'h3);
        check_val("s2_done_l50", 32'(bus.seq_done), 32'h0);
        check_val("s2_err_l50", 32'(bus.seq_err), 32'h1);
        tie0 = 4'b0000;

        // rst and sw_rst_req together while in error.
        rst = 1'b1;
        bus.sw_rst_req = 1'b1;
        tick();
        rst = 1'b0;
        bus.sw_rst_req = 1'b0;
        check_val("s6_rst_n", 32'(bus.dom_rst_n), 32'h0);
        check_val("s6_err", 32'(bus.seq_err), 32'h0);
        check_val("s6_err_dom", 32'(bus.err_dom), 32'h0);
        check_val("s6_done", 32'(bus.seq_done), 32'h0);
        tick();
        cyc = 0;
        run_nominal("s6");

        // Software restart mid-sequence.
        do_reset(1'b0);
        adv_to(19);
        check_val("s3_l19", 32'(bus.dom_rst_n), 32'h3);
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check_val("s3_abort_rst_n", 32'(bus.dom_rst_n), 32'h0);
        check_val("s3_abort_done", 32'(bus.seq_done), 32'h0);
        tick();
        cyc = 0;
        run_nominal("s3");

        // Ack loss on domain 1 after completion.
        tie0 = 4'b0010;
        tick();
        tie0 = 4'b0000;
        check_val("s4_done", 32'(bus.seq_done), 32'h0);
        check_val("s4_err", 32'(bus.seq_err), 32'h1);
        check_val("s4_err_dom", 32'(bus.err_dom), 32'h1);
        check_val("s4_rst_n", 32'(bus.dom_rst_n), 32'hf);
        repeat (5) tick();
        check_val("s4_err_sticky", 32'(bus.seq_err), 32'h1);
        check_val("s4_rst_n_sticky", 32'(bus.dom_rst_n), 32'hf);
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check_val("s4_clear_err", 32'(bus.seq_err), 32'h0);
        check_val("s4_clear_rst_n", 32'(bus.dom_rst_n), 32'h0);

        // All acks tied high: unreleased acks ignored, each release acked on the next edge.
        tie1 = 4'b1111;
        do_reset(1'b0);
        adv_to(8);
        check_val("s5_l8", 32'(bus.dom_rst_n), 32'h0);
        adv_to(9);
        check_val("s5_l9", 32'(bus.dom_rst_n), 32'h1);
        adv_to(14);
        check_val("s5_l14", 32'(bus.dom_rst_n), 32'h1);
        adv_to(15);
        check_val("s5_l15", 32'(bus.dom_rst_n), 32'h3);
        adv_to(21);
        check_val("s5_l21", 32'(bus.dom_rst_n), 32'h7);
        adv_to(27);
        check_val("s5_l27", 32'(bus.dom_rst_n), 32'hf);
        check_val("s5_done_l27", 32'(bus.seq_done), 32'h0);
        adv_to(28);
        check_val("s5_done_l28", 32'(bus.seq_done), 32'h1);
        check_val("s5_err_l28", 32'(bus.seq_err), 32'h0);
        tie1 = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
